// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - LSU uop encoding, FSM states and lane helper functions
package lsu_pkg;

  localparam logic [2:0] CLS_LOAD  = 3'b000;
  localparam logic [2:0] CLS_STORE = 3'b001;

  localparam logic [2:0] FN_B   = 3'b000;
  localparam logic [2:0] FN_H   = 3'b001;
  localparam logic [2:0] FN_W   = 3'b010;
  localparam logic [2:0] FN_LUI = 3'b011;
  localparam logic [2:0] FN_BU  = 3'b100;
  localparam logic [2:0] FN_HU  = 3'b101;

  localparam logic [5:0] NONE_UOP = 6'b111111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_WB   = 2'd2
  } lsu_state_t;

  // fn[1:0]: 00 byte, 01 half, 10 word for both signed and unsigned variants
  function automatic logic [3:0] f_be(input logic [2:0] fn, input logic [1:0] a);
    case (fn[1:0])
      2'b00:   f_be = 4'b0001 << a;
      2'b01:   f_be = a[1] ? 4'b1100 : 4'b0011;
      default: f_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] f_lane(input logic [2:0] fn, input logic [31:0] d);
    case (fn[1:0])
      2'b00:   f_lane = {4{d[7:0]}};
      2'b01:   f_lane = {2{d[15:0]}};
      default: f_lane = d;
    endcase
  endfunction

  function automatic logic [31:0] f_ext(input logic [2:0] fn, input logic [1:0] a,
                                        input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {a, 3'b000});
    h = 16'(w >> {a[1], 4'b0000});
    case (fn)
      FN_B:    f_ext = {{24{b[7]}}, b};
      FN_BU:   f_ext = {24'b0, b};
      FN_H:    f_ext = {{16{h[15]}}, h};
      FN_HU:   f_ext = {16'b0, h};
      default: f_ext = w;
    endcase
  endfunction

  function automatic logic f_misalign(input logic [2:0] fn, input logic [1:0] a);
    case (fn[1:0])
      2'b01:   f_misalign = a[0];
      2'b10:   f_misalign = |a;
      default: f_misalign = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte enables, store lane replication and load extension
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  func,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] ldata
);

  // pure lane steering, no state
  always_comb begin
    be         = f_be(func, addr_lo);
    wdata_lane = f_lane(func, wdata);
    ldata      = f_ext(func, addr_lo, rdata);
  end

endmodule

// File: rtl/lsu_issue_wb.sv
// rtl/lsu_issue_wb.sv - LSU issue consumer, memory sequencer and load writeback (option LSU_MISALIGN_TRAP_EN)
module lsu_issue_wb
  import lsu_pkg::*;
#(
  parameter int W_PA_REG   = 5,
  parameter int W_PD_UOPS  = 6,
  parameter int W_PD_DATA  = 32,
  parameter int W_AA_INSTR = 32,
  parameter int W_PC_SEL   = 2
) (
  input  logic                  clk,
  input  logic                  CFI_PC_rst,
  input  logic                  CFI_PC_clear,
  input  logic [W_PD_UOPS-1:0]  CDI_PD_uops1,
  input  logic [W_PD_UOPS-1:0]  CDI_PD_uops2,
  input  logic [W_PA_REG-1:0]   CDI_PA_r1,
  input  logic [W_PA_REG-1:0]   CDI_PA_r2,
  input  logic [W_PC_SEL-1:0]   CDI_PD_odr,
  input  logic [W_PD_UOPS-1:0]  DFI_PD_uops,
  input  logic [W_PD_DATA-1:0]  DFI_PD_rs,
  input  logic [W_PD_DATA-1:0]  DFI_PD_rt,
  input  logic [W_PD_DATA-1:0]  DFI_PD_imm,
  input  logic [W_AA_INSTR-1:0] DFI_AA_pc,
  output logic [W_PC_SEL-1:0]   CDO_PC_s1,
  output logic [W_PD_DATA-1:0]  CDO_PD_upt1,
  output logic [W_PA_REG-1:0]   CDO_PA_upt1,
  output logic                  MEM_req,
  output logic                  MEM_we,
  output logic [W_PD_DATA-1:0]  MEM_addr,
  output logic [W_PD_DATA-1:0]  MEM_wdata,
  output logic [3:0]            MEM_be,
  input  logic                  MEM_ack,
  input  logic [W_PD_DATA-1:0]  MEM_rdata,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic                  CFO_PC_exc,
  output logic [W_AA_INSTR-1:0] CFO_AA_excpc,
`endif
  output logic                  CFO_PC_busy
);

  lsu_state_t state, state_n;

  logic                 v0, v1, issue, is_ld, is_st, is_lui, mis, wb_exc;
  logic                 in_mem, in_wb, upd;
  logic [2:0]           d_cls, d_fn;
  logic [W_PD_DATA-1:0] ea;

  logic [2:0]           func_q;
  logic                 we_q;
  logic [W_PA_REG-1:0]  rd_q;
  logic [W_PD_DATA-1:0] rt_q, addr_q, data_q;

  logic [3:0]           be_l;
  logic [31:0]          wdata_l, ldata_l;

  logic                 unused_odr;

  assign v0     = (CDI_PD_uops1 != NONE_UOP);
  assign v1     = (CDI_PD_uops2 != NONE_UOP);
  assign d_cls  = DFI_PD_uops[5:3];
  assign d_fn   = DFI_PD_uops[2:0];
  assign ea     = DFI_PD_rs + DFI_PD_imm;
  assign is_lui = (d_cls == CLS_LOAD) && (d_fn == FN_LUI);
  assign is_ld  = (d_cls == CLS_LOAD) && (d_fn == FN_B || d_fn == FN_H || d_fn == FN_W ||
                                          d_fn == FN_BU || d_fn == FN_HU);
  assign is_st  = (d_cls == CLS_STORE) && (d_fn == FN_B || d_fn == FN_H || d_fn == FN_W);
  assign in_mem = (state == ST_MEM);
  assign in_wb  = (state == ST_WB);
  assign issue  = |CDO_PC_s1;
  assign unused_odr = ^CDI_PD_odr[W_PC_SEL-1:1];

`ifdef LSU_MISALIGN_TRAP_EN
  logic                  exc_q;
  logic [W_AA_INSTR-1:0] pc_q;

  assign mis          = (is_ld | is_st) & f_misalign(d_fn, ea[1:0]);
  assign wb_exc       = exc_q;
  assign CFO_PC_exc   = in_wb & exc_q & ~CFI_PC_clear;
  assign CFO_AA_excpc = CFO_PC_exc ? pc_q : '0;

  // misaligned accesses ride through WB as an exception pulse instead of an update
  always_ff @(posedge clk or posedge CFI_PC_rst) begin
    if (CFI_PC_rst) begin
      exc_q <= 1'b0;
      pc_q  <= '0;
    end else if (issue) begin
      exc_q <= mis;
      pc_q  <= DFI_AA_pc;
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^DFI_AA_pc;
  assign mis       = 1'b0;
  assign wb_exc    = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or posedge CFI_PC_rst) begin
    if (CFI_PC_rst) state <= ST_IDLE;
    else            state <= state_n;
  end

  // grant selection and next-state; grant is only offered while idle
  always_comb begin
    state_n   = state;
    CDO_PC_s1 = '0;
    case (state)
      ST_IDLE: begin
        if (!CFI_PC_clear && !CFI_PC_rst) begin
          if (v0 && (!v1 || CDI_PD_odr[0])) CDO_PC_s1[0] = 1'b1;
          else if (v1)                      CDO_PC_s1[1] = 1'b1;
          if (v0 || v1) begin
            if (is_lui || mis)       state_n = ST_WB;
            else if (is_ld || is_st) state_n = ST_MEM;
          end
        end
      end
      ST_MEM: begin
        // stores are committed once requested, so a flush only cancels loads
        if (we_q) begin
          if (MEM_ack) state_n = ST_IDLE;
        end else if (CFI_PC_clear) begin
          state_n = ST_IDLE;
        end else if (MEM_ack) begin
          state_n = ST_WB;
        end
      end
      ST_WB:   state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // capture the granted operation; load data lands in data_q on ack
  always_ff @(posedge clk or posedge CFI_PC_rst) begin
    if (CFI_PC_rst) begin
      func_q <= '0;
      we_q   <= 1'b0;
      rd_q   <= '0;
      rt_q   <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else if (issue) begin
      func_q <= d_fn;
      we_q   <= is_st;
      rd_q   <= CDO_PC_s1[0] ? CDI_PA_r1 : CDI_PA_r2;
      rt_q   <= DFI_PD_rt;
      addr_q <= ea;
      data_q <= DFI_PD_imm;
    end else if (in_mem && !we_q && !CFI_PC_clear && MEM_ack) begin
      data_q <= ldata_l;
    end
  end

  lsu_lane_align u_align (
    .addr_lo    (addr_q[1:0]),
    .func       (func_q),
    .wdata      (rt_q),
    .rdata      (MEM_rdata),
    .be         (be_l),
    .wdata_lane (wdata_l),
    .ldata      (ldata_l)
  );

  assign MEM_req     = in_mem;
  assign MEM_we      = in_mem & we_q;
  assign MEM_addr    = in_mem ? {addr_q[W_PD_DATA-1:2], 2'b00} : '0;
  assign MEM_be      = in_mem ? be_l : 4'b0000;
  assign MEM_wdata   = in_mem ? wdata_l : '0;

  assign upd         = in_wb & ~CFI_PC_clear & ~wb_exc;
  assign CDO_PA_upt1 = upd ? rd_q : '0;
  assign CDO_PD_upt1 = upd ? data_q : '0;
  assign CFO_PC_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_lsu_issue_wb.sv
// tb/tb_lsu_issue_wb.sv - scoreboard bench for lsu_issue_wb (option LSU_MISALIGN_TRAP_EN)
module tb_lsu_issue_wb;

  localparam logic [5:0] NONE = 6'b111111;
  localparam logic [5:0] U_LB = 6'b000000, U_LW = 6'b000010, U_LUI = 6'b000011;
  localparam logic [5:0] U_LBU = 6'b000100, U_SH = 6'b001001, U_SW = 6'b001010;
  localparam logic [5:0] U_NOP = 6'b010000;

  logic        clk, rst, clear;
  logic [5:0]  uops1, uops2, d_uops;
  logic [4:0]  r1, r2;
  logic [1:0]  odr;
  logic [31:0] d_rs, d_rt, d_imm, d_pc;
  logic [1:0]  s1;
  logic [31:0] upt_d;
  logic [4:0]  upt_a;
  logic        mem_req, mem_we, mem_ack, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        exc;
  logic [31:0] excpc;
`endif

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk_w;
  } mem_exp_t;

  mem_exp_t    mem_q[$];
  logic [36:0] upd_q[$];
  int          n_chk = 0;
  int          n_pass = 0;

  lsu_issue_wb dut (
    .clk          (clk),
    .CFI_PC_rst   (rst),
    .CFI_PC_clear (clear),
    .CDI_PD_uops1 (uops1),
    .CDI_PD_uops2 (uops2),
    .CDI_PA_r1    (r1),
    .CDI_PA_r2    (r2),
    .CDI_PD_odr   (odr),
    .DFI_PD_uops  (d_uops),
    .DFI_PD_rs    (d_rs),
    .DFI_PD_rt    (d_rt),
    .DFI_PD_imm   (d_imm),
    .DFI_AA_pc    (d_pc),
    .CDO_PC_s1    (s1),
    .CDO_PD_upt1  (upt_d),
    .CDO_PA_upt1  (upt_a),
    .MEM_req      (mem_req),
    .MEM_we       (mem_we),
    .MEM_addr     (mem_addr),
    .MEM_wdata    (mem_wdata),
    .MEM_be       (mem_be),
    .MEM_ack      (mem_ack),
    .MEM_rdata    (mem_rdata),
`ifdef LSU_MISALIGN_TRAP_EN
    .CFO_PC_exc   (exc),
    .CFO_AA_excpc (excpc),
`endif
    .CFO_PC_busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // update-bus scoreboard: every non-zero update must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && upt_a != 5'd0) begin
      if (upd_q.size() == 0) begin
        chk("upd_spurious", {upt_a, upt_d}, 37'd0);
      end else begin
        logic [36:0] e;
        e = upd_q.pop_front();
        chk("upd_rd", upt_a, e[36:32]);
        chk("upd_data", upt_d, e[31:0]);
      end
    end
  end

  task automatic issue(input logic [5:0] u1, input logic [5:0] u2, input logic [4:0] a1,
                       input logic [4:0] a2, input logic o, input logic [5:0] du,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm,
                       input logic [31:0] pc, input logic [1:0] exp_s1, input string tag);
    @(negedge clk);
    uops1 = u1; uops2 = u2; r1 = a1; r2 = a2; odr = {1'b0, o};
    d_uops = du; d_rs = rs; d_rt = rt; d_imm = imm; d_pc = pc;
    #1 chk({tag, "_s1"}, s1, exp_s1);
    @(posedge clk); #1;
    uops1 = NONE; uops2 = NONE;
  endtask

  task automatic mem_txn(input int delay, input logic [31:0] rdata);
    mem_exp_t e;
    int n;
    e = '{we: 1'b0, addr: 32'd0, be: 4'd0, wdata: 32'd0, chk_w: 1'b0};
    if (mem_q.size() != 0) e = mem_q.pop_front();
    n = 0;
    @(negedge clk);
    while (!mem_req && n < 8) begin n++; @(negedge clk); end
    chk("mem_req", mem_req, 1);
    chk("mem_busy", busy, 1);
    for (int i = 0; i <= delay; i++) begin
      if (i > 0) @(negedge clk);
      chk("mem_req_hold", mem_req, 1);
      chk("mem_we", mem_we, e.we);
      chk("mem_addr", mem_addr, e.addr);
      chk("mem_be", mem_be, e.be);
      if (e.chk_w) chk("mem_wdata", mem_wdata, e.wdata);
    end
    mem_ack = 1'b1; mem_rdata = rdata;
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = 32'd0;
  endtask

  task automatic drained(input string tag);
    @(negedge clk); #2;
    chk(tag, upd_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; clear = 1'b0; uops1 = NONE; uops2 = NONE; r1 = 0; r2 = 0; odr = 0;
    d_uops = NONE; d_rs = 0; d_rt = 0; d_imm = 0; d_pc = 0; mem_ack = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_s1", s1, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_upt_a", upt_a, 0);
    chk("rst_upt_d", upt_d, 0);
    rst = 1'b0;

    // LW from cand0 only; next grant blocked during WB
    mem_q.push_back('{we: 1'b0, addr: 32'h104, be: 4'hf, wdata: 32'd0, chk_w: 1'b0});
    upd_q.push_back({5'd5, 32'hDEADBEEF});
    issue(U_LW, NONE, 5'd5, 5'd0, 1'b0, U_LW, 32'h100, 32'h0, 32'h4, 32'h0, 2'b01, "lw");
    mem_txn(0, 32'hDEADBEEF);
    uops1 = U_LW;
    @(negedge clk); #2;
    chk("wb_no_grant", s1, 0);
    chk("lw_upd_drained", upd_q.size(), 0);
    uops1 = NONE;

    // both valid, cand1 older: LB then LBU at 0x103
    mem_q.push_back('{we: 1'b0, addr: 32'h100, be: 4'b1000, wdata: 32'd0, chk_w: 1'b0});
    upd_q.push_back({5'd9, 32'hFFFFFF80});
    issue(U_LW, U_LB, 5'd4, 5'd9, 1'b0, U_LB, 32'h100, 32'h0, 32'h3, 32'h0, 2'b10, "lb");
    mem_txn(0, 32'h80123456);
    drained("lb_upd_drained");
    mem_q.push_back('{we: 1'b0, addr: 32'h100, be: 4'b1000, wdata: 32'd0, chk_w: 1'b0});
    upd_q.push_back({5'd9, 32'h00000080});
    issue(U_LW, U_LBU, 5'd4, 5'd9, 1'b0, U_LBU, 32'h100, 32'h0, 32'h3, 32'h0, 2'b10, "lbu");
    mem_txn(1, 32'h80123456);
    drained("lbu_upd_drained");

    // SH at 0x202, no update expected
    mem_q.push_back('{we: 1'b1, addr: 32'h200, be: 4'b1100, wdata: 32'hABCDABCD, chk_w: 1'b1});
    issue(U_SH, NONE, 5'd3, 5'd0, 1'b0, U_SH, 32'h200, 32'h1234ABCD, 32'h2, 32'h0, 2'b01, "sh");
    mem_txn(1, 32'h0);
    @(negedge clk); #2;
    chk("sh_idle", busy, 0);

    // LUI: update one cycle after grant, no memory access
    upd_q.push_back({5'd7, 32'h12345000});
    issue(NONE, U_LUI, 5'd0, 5'd7, 1'b0, U_LUI, 32'h0, 32'h0, 32'h12345000, 32'h0, 2'b10, "lui");
    @(negedge clk); #2;
    chk("lui_no_req", mem_req, 0);
    chk("lui_upd_drained", upd_q.size(), 0);

    // both valid, cand0 older and a NOP: granted, dropped
    issue(U_NOP, U_LW, 5'd1, 5'd2, 1'b1, U_NOP, 32'h0, 32'h0, 32'h0, 32'h0, 2'b01, "nop");
    @(negedge clk); #1;
    chk("nop_busy", busy, 0);
    chk("nop_req", mem_req, 0);

    // clear in IDLE blocks the grant
    @(negedge clk);
    uops1 = U_LW; clear = 1'b1;
    #1 chk("clr_idle_s1", s1, 0);
    @(posedge clk); #1;
    uops1 = NONE; clear = 1'b0;
    @(negedge clk); #1;
    chk("clr_idle_busy", busy, 0);

    // clear in WB suppresses the LUI update
    issue(U_LUI, NONE, 5'd3, 5'd0, 1'b0, U_LUI, 32'h0, 32'h0, 32'h55, 32'h0, 2'b01, "wbclr");
    @(negedge clk);
    clear = 1'b1;
    #1 chk("wbclr_upt_a", upt_a, 0);
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk); #1 chk("wbclr_busy", busy, 0);

    // clear during a load: request dropped, late ack ignored
    issue(U_LW, NONE, 5'd8, 5'd0, 1'b0, U_LW, 32'h400, 32'h0, 32'h0, 32'h0, 2'b01, "clrld");
    @(negedge clk); #1;
    chk("clrld_req0", mem_req, 1);
    clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk); #1;
    chk("clrld_req1", mem_req, 0);
    chk("clrld_busy", busy, 0);
    @(negedge clk); @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h99;
    @(posedge clk); #1 mem_ack = 1'b0;
    @(negedge clk); #1 chk("clrld_after_ack", busy, 0);

    // clear during a store: request held until ack
    issue(U_SW, NONE, 5'd8, 5'd0, 1'b0, U_SW, 32'h300, 32'hCAFEF00D, 32'h0, 32'h0, 2'b01, "clrst");
    @(negedge clk); #1;
    clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("clrst_req", mem_req, 1);
      chk("clrst_addr", mem_addr, 32'h300);
      chk("clrst_wdata", mem_wdata, 32'hCAFEF00D);
    end
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0; clear = 1'b0;
    @(negedge clk); #1;
    chk("clrst_done_req", mem_req, 0);
    chk("clrst_done_busy", busy, 0);

    // misaligned word access
`ifdef LSU_MISALIGN_TRAP_EN
    issue(U_LW, NONE, 5'd6, 5'd0, 1'b0, U_LW, 32'h100, 32'h0, 32'h2, 32'h40000010, 2'b01, "mis");
    @(negedge clk); #1;
    chk("mis_exc", exc, 1);
    chk("mis_excpc", excpc, 32'h40000010);
    chk("mis_no_req", mem_req, 0);
    chk("mis_no_upd", upt_a, 0);
    @(negedge clk); #1;
    chk("mis_exc_end", exc, 0);
    chk("mis_idle", busy, 0);
`else
    mem_q.push_back('{we: 1'b0, addr: 32'h100, be: 4'hf, wdata: 32'd0, chk_w: 1'b0});
    upd_q.push_back({5'd6, 32'h11223344});
    issue(U_LW, NONE, 5'd6, 5'd0, 1'b0, U_LW, 32'h100, 32'h0, 32'h2, 32'h40000010, 2'b01, "mis");
    mem_txn(0, 32'h11223344);
    drained("mis_upd_drained");
`endif

    repeat (2) @(negedge clk);
    chk("upd_q_empty", upd_q.size(), 0);
    chk("mem_q_empty", mem_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lsu_issue_wb.md
Name: lsu_issue_wb

Overview:
- Consumer end of the load/store reservation station's issue interface.
- Each cycle it is idle, it inspects the two ready candidates, grants the older one via the select strobe, and captures the muxed operand data in the same cycle.
- It then executes the load/store against a valid/ack data-memory port and broadcasts the load result on the update bus, which the reservation station snoops.
- Sits between the reservation station and the data-memory port.

Parameters:
- W_PA_REG, 5, register address width
- W_PD_UOPS, 6, uop width; all-ones = no candidate
- W_PD_DATA, 32, data and memory address width
- W_AA_INSTR, 32, pc width
- W_PC_SEL, 2, select/order bus width

Ports:
- clk  in  1  clock; all state updates on rising edge
- CFI_PC_rst  in  1  asynchronous, active-high reset
- CFI_PC_clear  in  1  synchronous pipeline flush
- CDI_PD_uops1  in  W_PD_UOPS  candidate-0 uop
- CDI_PD_uops2  in  W_PD_UOPS  candidate-1 uop
- CDI_PA_r1  in  W_PA_REG  candidate-0 rd
- CDI_PA_r2  in  W_PA_REG  candidate-1 rd
- CDI_PD_odr  in  W_PC_SEL  bit0=1: candidate 0 is older
- DFI_PD_uops  in  W_PD_UOPS  selected uop (combinational from select)
- DFI_PD_rs  in  W_PD_DATA  selected base operand
- DFI_PD_rt  in  W_PD_DATA  selected store data
- DFI_PD_imm  in  W_PD_DATA  selected immediate, already extended
- DFI_AA_pc  in  W_AA_INSTR  selected pc
- CDO_PC_s1  out  W_PC_SEL  one-hot grant: bit0 = cand0, bit1 = cand1
- CDO_PD_upt1  out  W_PD_DATA  update data
- CDO_PA_upt1  out  W_PA_REG  update rd; 0 = no update
- MEM_req  out  1  memory request valid
- MEM_we  out  1  1 = store
- MEM_addr  out  W_PD_DATA  byte address
- MEM_wdata  out  W_PD_DATA  store data, lane-aligned
- MEM_be  out  4  byte enables
- MEM_ack  in  1  request accepted; load data valid this cycle
- MEM_rdata  in  W_PD_DATA  load word
- CFO_PC_busy  out  1  state != IDLE

Behaviour:
- Uop encoding: [5:3] = class (000 load, 001 store); [2:0] = function.
  - Loads: LB 000, LH 001, LW 010, LUI 011, LBU 100, LHU 101.
  - Stores: SB 000, SH 001, SW 010.
  - Any other uop is treated as a NOP: granted, dropped, no memory access, no update.
- States: IDLE, MEM, WB.
- Reset (async): state=IDLE; all outputs 0; captured registers 0.
- IDLE, grant:
  - A candidate is valid when its uop is not all-ones.
  - If neither candidate is valid, or CFI_PC_clear=1, then CDO_PC_s1=00.
  - If exactly one is valid, grant it.
  - If both are valid, grant the older per CDI_PD_odr[0].
  - CDO_PC_s1 is combinational. On that same edge, latch DFI_* and the matching rd, and compute addr = rs + imm (mod 2^32).
- IDLE, next state:
  - LUI: go to WB with data = imm.
  - Load or store: go to MEM.
  - NOP: stay in IDLE.
- MEM:
  - MEM_req=1, with MEM_addr, MEM_we, MEM_be and MEM_wdata held stable until MEM_ack.
  - MEM_addr is word-aligned (addr[1:0] forced 00).
  - MEM_be: byte = 1<<a[1:0]; half = 0011<<(a[1]*2); word = 1111.
  - MEM_wdata: the rt byte/half is replicated into the addressed lane.
  - On ack:
    - Load: extract the lane, sign-extend (LB/LH/LW) or zero-extend (LBU/LHU), register the result, go to WB.
    - Store: go to IDLE.
- WB:
  - For exactly one cycle, CDO_PA_upt1 = rd and CDO_PD_upt1 = data.
  - If rd = 0, CDO_PA_upt1 = 0 (no update).
  - Next state is IDLE.
  - Outside WB, both update outputs are 0.
- Throughput:
  - Issue at cycle T; MEM_req from T+1; ack at A; update at A+1; next grant possible at A+2.
  - With a same-cycle ack, a load occupies 3 cycles.
- CFI_PC_clear:
  - IDLE: no grant.
  - WB: suppress the update, go to IDLE.
  - MEM with a load: drop MEM_req on the next edge and go to IDLE; an ack arriving on the clear cycle is ignored.
  - MEM with a store: the store is not cancelled; hold the request until ack, then IDLE.
- Async reset during MEM abandons the request immediately. The memory side must tolerate this.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Enabled:
  - Adds output CFO_PC_exc (1) and CFO_AA_excpc (W_AA_INSTR).
  - A half access with a[0]=1, or a word access with a[1:0]≠00, skips MEM and produces no update.
  - Pulses CFO_PC_exc for one cycle with the uop's pc, then returns to IDLE.
- Disabled: the low address bits are truncated silently (half aligned to a[1], word to a[1:0]=00).

Decomposition:
- Package lsu_pkg holds:
  - uop class/function localparams;
  - NONE_UOP (all-ones);
  - state encoding;
  - byte-enable and extension helper functions.
- One sub-module: lsu_lane_align, combinational. It takes addr, func and data, and returns MEM_be, lane-replicated wdata, and the extended load data.

Test Plan:
- cand0=LW (000010), rs=0x100, imm=4, rd=5; cand1 none → s1=01 in the same cycle; MEM_addr=0x104, be=1111; ack with rdata=0xDEADBEEF → upt1 addr=5, data=0xDEADBEEF for one cycle.
- Both candidates valid, odr[0]=0; cand1 LB at addr 0x103, rdata=0x80xxxxxx → s1=10, be=1000, upt1=0xFFFFFF80. LBU at the same address gives 0x00000080.
- SH with rt=0x1234ABCD at addr 0x202 → be=1100, wdata=0xABCDABCD, we=1; no update after ack.
- LUI, imm=0x12345000, rd=7 → no MEM_req; update addr=7, data=0x12345000 one cycle after grant.
- Load in MEM, clear asserted, ack delayed 3 cycles → MEM_req low after 1 cycle, no update. A store in the same situation keeps MEM_req until ack.
- With the macro enabled: LW at 0x102 → no MEM_req, CFO_PC_exc pulse carrying the pc. With it disabled: MEM_addr=0x100.
